// File: rtl/alu_pkg.sv
// Shared ALU opcode, flag-index and port definitions for the shared-ALU arbiter.
package alu_pkg;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_ADDC    = 3'b100;
    localparam logic [2:0] ALU_SUBC    = 3'b101;
    localparam logic [2:0] ALU_ILLEGAL = 3'b110;
    localparam logic [2:0] ALU_XOR     = 3'b111;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    function automatic logic is_illegal(input logic [2:0] op);
        return op == ALU_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
interface alu_share_arb_if #(
    parameter int W   = 32,
    parameter int OPW = 3
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic [OPW-1:0] req0_op;
    logic [OPW-1:0] req1_op;
    logic           req0_swap;
    logic           req1_swap;
    logic           req0_setf;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_op;
    logic           alu_swap;
    logic [W-1:0]   alu_res;
    logic [3:0]     alu_flg;

    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp0_data;
    logic [W-1:0]   resp1_data;
    logic [3:0]     resp0_flg;
    logic [3:0]     resp1_flg;
    logic [3:0]     flags_q;

    // The arbiter side.
    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
               req0_swap, req1_swap, req0_setf, resp_ready, alu_res, alu_flg,
        output req_ready, alu_a, alu_b, alu_op, alu_swap,
               resp_valid, resp0_data, resp1_data, resp0_flg, resp1_flg, flags_q
    );

    // The requester/ALU environment side.
    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
               req0_swap, req1_swap, req0_setf, resp_ready, alu_res, alu_flg,
        input  req_ready, alu_a, alu_b, alu_op, alu_swap,
               resp_valid, resp0_data, resp1_data, resp0_flg, resp1_flg, flags_q
    );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way arbiter: round-robin on contention when RR_ENABLE, otherwise port 0 wins.
module rr_arb2
    import alu_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    port_e last_grant;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (RR_ENABLE && last_grant == PORT0) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to PORT1 so the first contended grant after reset goes to port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT1;
        end else if (grant[1]) begin
            last_grant <= PORT1;
        end else if (grant[0]) begin
            last_grant <= PORT0;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between the execute stage (port 0) and the AGU (port 1),
// with one registered response slot per port and the architectural NZCV register.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int W         = 32,
    parameter int OPW       = 3,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    alu_share_arb_if.slave  bus
);

    logic [1:0]     elig;
    logic [1:0]     grant;
    logic [1:0]     accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [OPW-1:0] sel_op;
    logic           sel_swap;
    logic           sel_illegal;
    logic [W-1:0]   res_eff;
    logic [3:0]     flg_eff;

    logic [1:0]     resp_valid_q;
    logic [W-1:0]   resp_data_q [2];
    logic [3:0]     resp_flg_q  [2];
    logic [3:0]     flags_reg;

    // A slot that is being drained this cycle is free for a new result.
    assign elig = bus.req_valid & (~resp_valid_q | bus.resp_ready);

    rr_arb2 #(
        .RR_ENABLE (RR_ENABLE)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .elig  (elig),
        .grant (grant)
    );

    assign bus.req_ready = grant;
    assign accept        = bus.req_valid & grant;

    always_comb begin
        sel_a    = bus.req0_a;
        sel_b    = bus.req0_b;
        sel_op   = bus.req0_op;
        sel_swap = bus.req0_swap;
        if (grant[1]) begin
            sel_a    = bus.req1_a;
            sel_b    = bus.req1_b;
            sel_op   = bus.req1_op;
            sel_swap = bus.req1_swap;
        end
    end

    assign bus.alu_a    = sel_a;
    assign bus.alu_b    = sel_b;
    assign bus.alu_op   = sel_op;
    assign bus.alu_swap = sel_swap;

    // The illegal opcode still completes, but never exposes ALU output.
    assign sel_illegal = is_illegal(3'(sel_op));
    assign res_eff     = sel_illegal ? '0 : bus.alu_res;
    assign flg_eff     = sel_illegal ? 4'b0000 : bus.alu_flg;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                resp_data_q[i] <= '0;
                resp_flg_q[i]  <= 4'b0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    resp_valid_q[i] <= 1'b1;
                    resp_data_q[i]  <= res_eff;
                    resp_flg_q[i]   <= flg_eff;
                end else if (bus.resp_ready[i]) begin
                    resp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Only the execute stage owns the architectural flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else if (accept[0] && bus.req0_setf && !sel_illegal) begin
            flags_reg <= bus.alu_flg;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp0_data = resp_data_q[0];
    assign bus.resp1_data = resp_data_q[1];
    assign bus.resp0_flg  = resp_flg_q[0];
    assign bus.resp1_flg  = resp_flg_q[1];
    assign bus.flags_q    = flags_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench: behavioural ALU + arbiter model, directed scenarios, random traffic.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        sw0, sw1, setf0;

    int total = 0;
    int bad   = 0;

    logic [1:0] grant_seen;
    logic [1:0] grant_fp_seen;

    alu_share_arb_if #(.W(32), .OPW(3)) bus ();
    alu_share_arb_if #(.W(32), .OPW(3)) bus_fp ();

    // Reference ALU: ARM-style flags, C = no-borrow on subtract; opcode 110 returns junk.
    function automatic logic [35:0] alu_calc(input logic [31:0] ia, input logic [31:0] ib,
                                             input logic [2:0] op, input logic sw);
        logic [31:0] x, y, r;
        logic        c, v;
        logic [32:0] wide;
        x = sw ? ib : ia;
        y = sw ? ia : ib;
        c = 1'b0;
        v = 1'b0;
        wide = '0;
        case (op)
            3'b000: begin wide = {1'b0, x} + {1'b0, y};         r = wide[31:0]; c = wide[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
            3'b100: begin wide = {1'b0, x} + {1'b0, y} + 33'd1; r = wide[31:0]; c = wide[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
            3'b001: begin wide = {1'b0, x} + {1'b0, ~y} + 33'd1; r = wide[31:0]; c = wide[32]; v = (x[31] != y[31]) && (r[31] != x[31]); end
            3'b101: begin wide = {1'b0, x} + {1'b0, ~y};        r = wide[31:0]; c = wide[32]; v = (x[31] != y[31]) && (r[31] != x[31]); end
            3'b010: r = x & y;
            3'b011: r = x | y;
            3'b111: r = x ^ y;
            default: return {4'b1111, x ^ 32'h5A5A_5A5A};
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign bus.req_valid  = req_valid;
    assign bus.resp_ready = resp_ready;
    assign bus.req0_a = a0;  assign bus.req0_b = b0;  assign bus.req0_op = op0;
    assign bus.req1_a = a1;  assign bus.req1_b = b1;  assign bus.req1_op = op1;
    assign bus.req0_swap = sw0;  assign bus.req1_swap = sw1;  assign bus.req0_setf = setf0;
    assign {bus.alu_flg, bus.alu_res} = alu_calc(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_swap);

    assign bus_fp.req_valid  = req_valid;
    assign bus_fp.resp_ready = 2'b11;
    assign bus_fp.req0_a = a0;  assign bus_fp.req0_b = b0;  assign bus_fp.req0_op = op0;
    assign bus_fp.req1_a = a1;  assign bus_fp.req1_b = b1;  assign bus_fp.req1_op = op1;
    assign bus_fp.req0_swap = sw0;  assign bus_fp.req1_swap = sw1;  assign bus_fp.req0_setf = setf0;
    assign {bus_fp.alu_flg, bus_fp.alu_res} = alu_calc(bus_fp.alu_a, bus_fp.alu_b, bus_fp.alu_op, bus_fp.alu_swap);

    alu_share_arb #(.W(32), .OPW(3), .RR_ENABLE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu_share_arb #(.W(32), .OPW(3), .RR_ENABLE(1'b0)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fp)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model state: what each response slot and the flags register must hold.
    logic        m_ok = 1'b0;
    logic [1:0]  m_valid;
    logic [31:0] m_data [2];
    logic [3:0]  m_flg  [2];
    logic [3:0]  m_flags;
    int          m_last;
    logic [1:0]  e_el, e_g, e_fp;
    logic [35:0] e_r;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
    logic        e_sw;

    always @(negedge clk) begin
        e_g = 2'b00;
        if (!reset && m_ok) begin
            e_el = req_valid & (~m_valid | resp_ready);
            if (e_el == 2'b11)      e_g = (m_last == 0) ? 2'b10 : 2'b01;
            else if (e_el == 2'b01) e_g = 2'b01;
            else if (e_el == 2'b10) e_g = 2'b10;
        end
        e_a  = e_g[1] ? a1  : a0;
        e_b  = e_g[1] ? b1  : b0;
        e_op = e_g[1] ? op1 : op0;
        e_sw = e_g[1] ? sw1 : sw0;
        e_fp = reset ? 2'b00 : (req_valid[0] ? 2'b01 : (req_valid[1] ? 2'b10 : 2'b00));
        checkOutput("fp_req_ready", 64'(bus_fp.req_ready), 64'(e_fp));
        if (m_ok) begin
            checkOutput("req_ready",  64'(bus.req_ready),  64'(e_g));
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
            checkOutput("resp0_data", 64'(bus.resp0_data), 64'(m_data[0]));
            checkOutput("resp1_data", 64'(bus.resp1_data), 64'(m_data[1]));
            checkOutput("resp0_flg",  64'(bus.resp0_flg),  64'(m_flg[0]));
            checkOutput("resp1_flg",  64'(bus.resp1_flg),  64'(m_flg[1]));
            checkOutput("flags_q",    64'(bus.flags_q),    64'(m_flags));
            checkOutput("alu_ab",     {bus.alu_a, bus.alu_b}, {e_a, e_b});
            checkOutput("alu_opswap", 64'({bus.alu_op, bus.alu_swap}), 64'({e_op, e_sw}));
        end
        if (reset) begin
            m_ok = 1'b1;
            m_valid = 2'b00;
            m_data[0] = '0; m_data[1] = '0;
            m_flg[0] = '0;  m_flg[1] = '0;
            m_flags = '0;
            m_last = 1;
        end else if (m_ok) begin
            for (int i = 0; i < 2; i++) begin
                if (e_g[i]) begin
                    e_r = (i == 0) ? alu_calc(a0, b0, op0, sw0) : alu_calc(a1, b1, op1, sw1);
                    m_valid[i] = 1'b1;
                    m_data[i]  = (e_op == ALU_ILLEGAL) ? 32'd0 : e_r[31:0];
                    m_flg[i]   = (e_op == ALU_ILLEGAL) ? 4'd0  : e_r[35:32];
                    m_last     = i;
                    if (i == 0 && setf0 && op0 != ALU_ILLEGAL) m_flags = e_r[35:32];
                end else if (resp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; samples the grant mid-cycle and returns at the next posedge+1.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rr,
                                 input logic [31:0] ia0, input logic [31:0] ib0, input logic [2:0] iop0,
                                 input logic isw0, input logic isetf0,
                                 input logic [31:0] ia1, input logic [31:0] ib1, input logic [2:0] iop1,
                                 input logic isw1);
        req_valid = v;  resp_ready = rr;
        a0 = ia0; b0 = ib0; op0 = iop0; sw0 = isw0; setf0 = isetf0;
        a1 = ia1; b1 = ib1; op1 = iop1; sw1 = isw1;
        #2;
        grant_seen    = bus.req_ready;
        grant_fp_seen = bus_fp.req_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; resp_ready = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        op0 = '0; op1 = '0; sw0 = 1'b0; sw1 = 1'b0; setf0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("lit_reset_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("lit_reset_flags", 64'(bus.flags_q), 64'd0);

        applyStimulus(2'b01, 2'b11, 32'd5, 32'd7, ALU_ADD, 1'b0, 1'b1, 32'd0, 32'd0, ALU_ADD, 1'b0);
        checkOutput("lit_add_grant", 64'(grant_seen), 64'b01);
        checkOutput("lit_add_data",  64'(bus.resp0_data), 64'd12);
        checkOutput("lit_add_flg",   64'(bus.resp0_flg), 64'b0000);
        checkOutput("lit_add_flags", 64'(bus.flags_q), 64'b0000);

        reset = 1'b1;
        applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 2'b11, 32'(k), 32'd1, ALU_ADD, 1'b0, 1'b0, 32'(k), 32'd2, ALU_OR, 1'b0);
            checkOutput("lit_rr_grant", 64'(grant_seen), (k % 2 == 0) ? 64'b01 : 64'b10);
            checkOutput("lit_fp_grant", 64'(grant_fp_seen), 64'b01);
        end

        applyStimulus(2'b10, 2'b11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 32'd3, 32'd3, ALU_SUB, 1'b0);
        checkOutput("lit_sub_data", 64'(bus.resp1_data), 64'd0);
        checkOutput("lit_sub_flg",  64'(bus.resp1_flg), 64'b0110);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, 2'b01, 32'(k + 10), 32'd1, ALU_ADD, 1'b0, 1'b0, 32'd9, 32'd4, ALU_SUB, 1'b0);
            checkOutput("lit_hold_grant", 64'(grant_seen), 64'b01);
            checkOutput("lit_hold_data",  64'(bus.resp1_data), 64'd0);
            checkOutput("lit_hold_flg",   64'(bus.resp1_flg), 64'b0110);
            checkOutput("lit_hold_p0",    64'(bus.resp0_data), 64'(k + 11));
        end
        applyStimulus(2'b10, 2'b11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 32'd9, 32'd4, ALU_SUB, 1'b0);
        checkOutput("lit_drain_grant", 64'(grant_seen), 64'b10);
        checkOutput("lit_drain_data",  64'(bus.resp1_data), 64'd5);

        applyStimulus(2'b01, 2'b11, 32'h8000_0000, 32'd1, ALU_SUB, 1'b0, 1'b1, 32'd0, 32'd0, ALU_ADD, 1'b0);
        checkOutput("lit_ovf_data",  64'(bus.resp0_data), 64'h7FFF_FFFF);
        checkOutput("lit_ovf_flg",   64'(bus.resp0_flg), 64'b0011);
        checkOutput("lit_ovf_flags", 64'(bus.flags_q), 64'b0011);
        applyStimulus(2'b10, 2'b11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b0);
        checkOutput("lit_p1_data",  64'(bus.resp1_data), 64'd2);
        checkOutput("lit_p1_flags", 64'(bus.flags_q), 64'b0011);

        applyStimulus(2'b01, 2'b11, 32'hFFFF_FFFF, 32'd1, ALU_ILLEGAL, 1'b0, 1'b1, 32'd0, 32'd0, ALU_ADD, 1'b0);
        checkOutput("lit_ill_data",  64'(bus.resp0_data), 64'd0);
        checkOutput("lit_ill_flg",   64'(bus.resp0_flg), 64'd0);
        checkOutput("lit_ill_flags", 64'(bus.flags_q), 64'b0011);

        applyStimulus(2'b11, 2'b00, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0);
        checkOutput("lit_full_valid", 64'(bus.resp_valid), 64'b11);
        reset = 1'b1;
        applyStimulus(2'b11, 2'b00, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0);
        reset = 1'b0;
        checkOutput("lit_rst_valid", 64'(bus.resp_valid), 64'b00);
        checkOutput("lit_rst_flags", 64'(bus.flags_q), 64'd0);
        applyStimulus(2'b11, 2'b11, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0);
        checkOutput("lit_rst_grant", 64'(grant_seen), 64'b01);

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            applyStimulus(2'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                          rand_operand(), rand_operand(), 3'($urandom), 1'($urandom), 1'($urandom),
                          rand_operand(), rand_operand(), 3'($urandom), 1'($urandom));
        end
        reset = 1'b0;
        applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
